rsp_s2_dma_alen_gen: RTL and testbench

Burst-descriptor generator for the rsp_s2 DMA write path. It sits directly upstream of the AXI write engine and fills that engine's alen FIFO. Each descriptor is one 12-bit word `{s_last, f_last, p_last, c_last, awlen[7:0]}`. The block walks a segment/frame/part loop from a configuration snapshot and splits each segment into AXI bursts of at most MAX_BURST beats. It halts after each part until resume, and stops after the final burst.

---
 rtl/rsp_s2_dma_alen_gen.sv | 195 +++++++++++++++++++
 tb/tb_rsp_s2_dma_alen_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_s2_dma_alen_gen.sv
// Burst-descriptor generator for the rsp_s2 DMA write path.
// Walks a segment/frame/part loop from a config snapshot and pushes one
// {s_last, f_last, p_last, c_last, awlen} word per AXI burst into the alen FIFO.
module rsp_s2_dma_alen_gen #(
  parameter int MAX_BURST = 16,
  parameter int LEN_BITS  = 16,
  parameter int CNT_BITS  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update,
  input  logic                resume,
  input  logic [LEN_BITS-1:0] SEG_LEN,
  input  logic [CNT_BITS-1:0] SEG_NUM,
  input  logic [CNT_BITS-1:0] FRM_NUM,
  input  logic [CNT_BITS-1:0] PART_NUM,
  output logic                alen_fifo_push,
  output logic [11:0]         alen_fifo_din,
  input  logic                alen_fifo_afull,
  output logic                busy,
  output logic                paused,
  output logic                cfg_err,
  output logic [15:0]         burst_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] seg_len_q, seg_len_d;
  logic [CNT_BITS-1:0] seg_num_q, seg_num_d;
  logic [CNT_BITS-1:0] frm_num_q, frm_num_d;
  logic [CNT_BITS-1:0] part_num_q, part_num_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic [CNT_BITS-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_BITS-1:0] frm_cnt_q, frm_cnt_d;
  logic [CNT_BITS-1:0] part_cnt_q, part_cnt_d;
  logic                push_q, push_d;
  logic [11:0]         din_q, din_d;
  logic                cfg_err_q, cfg_err_d;
  logic [15:0]         burst_cnt_q, burst_cnt_d;

  logic [8:0]          beats;
  logic [7:0]          awlen;
  logic                seg_end;
  logic                seg_last;
  logic                frm_last;
  logic                part_last;
  logic                cfg_bad;
  logic                s_last, f_last, p_last, c_last;

  // Burst sizing: beats never exceeds 256, so 9 bits hold it; awlen wraps 256 to 255.
  always_comb begin
    beats     = 9'd0;
    if (32'(rem_q) >= MAX_BURST) begin
      beats = 9'(MAX_BURST);
    end else begin
      beats = 9'(rem_q);
    end
    awlen     = beats[7:0] - 8'd1;
    seg_end   = (32'(rem_q) <= MAX_BURST);
    seg_last  = (seg_cnt_q == seg_num_q - CNT_BITS'(1));
    frm_last  = (frm_cnt_q == frm_num_q - CNT_BITS'(1));
    part_last = (part_cnt_q == part_num_q - CNT_BITS'(1));
    cfg_bad   = (SEG_LEN == '0) || (SEG_NUM == '0) || (FRM_NUM == '0) || (PART_NUM == '0);
  end

  // Next-state, counter walk and descriptor assembly; update overrides everything.
  always_comb begin
    state_d     = state_q;
    seg_len_d   = seg_len_q;
    seg_num_d   = seg_num_q;
    frm_num_d   = frm_num_q;
    part_num_d  = part_num_q;
    rem_d       = rem_q;
    seg_cnt_d   = seg_cnt_q;
    frm_cnt_d   = frm_cnt_q;
    part_cnt_d  = part_cnt_q;
    push_d      = 1'b0;
    din_d       = din_q;
    cfg_err_d   = 1'b0;
    burst_cnt_d = burst_cnt_q;
    s_last      = 1'b0;
    f_last      = 1'b0;
    p_last      = 1'b0;
    c_last      = 1'b0;

    case (state_q)
      GEN: begin
        if (!alen_fifo_afull) begin
          push_d      = 1'b1;
          burst_cnt_d = burst_cnt_q + 16'd1;
          rem_d       = rem_q - LEN_BITS'(beats);
          if (seg_end) begin
            s_last = 1'b1;
            rem_d  = seg_len_q;
            if (seg_last) begin
              seg_cnt_d = '0;
              f_last    = 1'b1;
              if (frm_last) begin
                frm_cnt_d = '0;
                if (part_last) begin
                  part_cnt_d = '0;
                  c_last     = 1'b1;
                  state_d    = IDLE;
                end else begin
                  part_cnt_d = part_cnt_q + CNT_BITS'(1);
                  p_last     = 1'b1;
                  state_d    = PAUSE;
                end
              end else begin
                frm_cnt_d = frm_cnt_q + CNT_BITS'(1);
              end
            end else begin
              seg_cnt_d = seg_cnt_q + CNT_BITS'(1);
            end
          end
          din_d = {s_last, f_last, p_last, c_last, awlen};
        end
      end
      PAUSE: begin
        if (resume) begin
          state_d = GEN;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (update) begin
      push_d      = 1'b0;
      din_d       = din_q;
      burst_cnt_d = '0;
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
        state_d   = IDLE;
      end else begin
        seg_len_d  = SEG_LEN;
        seg_num_d  = SEG_NUM;
        frm_num_d  = FRM_NUM;
        part_num_d = PART_NUM;
        rem_d      = SEG_LEN;
        seg_cnt_d  = '0;
        frm_cnt_d  = '0;
        part_cnt_d = '0;
        state_d    = GEN;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      seg_len_q   <= '0;
      seg_num_q   <= '0;
      frm_num_q   <= '0;
      part_num_q  <= '0;
      rem_q       <= '0;
      seg_cnt_q   <= '0;
      frm_cnt_q   <= '0;
      part_cnt_q  <= '0;
      push_q      <= 1'b0;
      din_q       <= '0;
      cfg_err_q   <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_len_q   <= seg_len_d;
      seg_num_q   <= seg_num_d;
      frm_num_q   <= frm_num_d;
      part_num_q  <= part_num_d;
      rem_q       <= rem_d;
      seg_cnt_q   <= seg_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      part_cnt_q  <= part_cnt_d;
      push_q      <= push_d;
      din_q       <= din_d;
      cfg_err_q   <= cfg_err_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign alen_fifo_push = push_q;
  assign alen_fifo_din  = din_q;
  assign cfg_err        = cfg_err_q;
  assign burst_cnt      = burst_cnt_q;
  assign busy           = (state_q != IDLE);
  assign paused         = (state_q == PAUSE);

endmodule

// File: tb/tb_rsp_s2_dma_alen_gen.sv
// Testbench for rsp_s2_dma_alen_gen: directed and randomized transfers checked
// against a nested-loop model of the segment/frame/part walk.
module tb_rsp_s2_dma_alen_gen;

  localparam int MAXB = 16;

  logic        clk;
  logic        rst;
  logic        update;
  logic        resume;
  logic [15:0] seg_len;
  logic [11:0] seg_num;
  logic [11:0] frm_num;
  logic [11:0] part_num;
  logic        alen_fifo_push;
  logic [11:0] alen_fifo_din;
  logic        alen_fifo_afull;
  logic        busy;
  logic        paused;
  logic        cfg_err;
  logic [15:0] burst_cnt;

  logic [11:0] exp_q[$];
  logic [15:0] exp_cnt;
  logic [11:0] last_pop;
  logic        afull_rec;
  int          pass_cnt;
  int          total_cnt;

  rsp_s2_dma_alen_gen #(
    .MAX_BURST(MAXB),
    .LEN_BITS (16),
    .CNT_BITS (12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .update         (update),
    .resume         (resume),
    .SEG_LEN        (seg_len),
    .SEG_NUM        (seg_num),
    .FRM_NUM        (frm_num),
    .PART_NUM       (part_num),
    .alen_fifo_push (alen_fifo_push),
    .alen_fifo_din  (alen_fifo_din),
    .alen_fifo_afull(alen_fifo_afull),
    .busy           (busy),
    .paused         (paused),
    .cfg_err        (cfg_err),
    .burst_cnt      (burst_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected descriptor list for a whole transfer, derived from the loop nest.
  task automatic buildExpected(input int slen, input int snum, input int fnum, input int pnum);
    int rem;
    int b;
    bit s_l, f_l, p_end;
    for (int p = 0; p < pnum; p++) begin
      for (int f = 0; f < fnum; f++) begin
        for (int s = 0; s < snum; s++) begin
          rem = slen;
          while (rem > 0) begin
            b     = (rem < MAXB) ? rem : MAXB;
            rem   = rem - b;
            s_l   = (rem == 0);
            f_l   = s_l && (s == snum - 1);
            p_end = f_l && (f == fnum - 1);
            exp_q.push_back({s_l, f_l, p_end && (p != pnum - 1), p_end && (p == pnum - 1), 8'(b - 1)});
          end
        end
      end
    end
  endtask

  // Output monitor: every push is matched in order against the model.
  always @(negedge clk) begin
    if (afull_rec) begin
      checkOutput("no_push_after_afull", 32'(alen_fifo_push), 32'd0);
    end
    if (alen_fifo_push) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_push", 32'(alen_fifo_push), 32'd0);
      end else begin
        last_pop = exp_q.pop_front();
        exp_cnt  = exp_cnt + 16'd1;
        checkOutput("descriptor", 32'(alen_fifo_din), 32'(last_pop));
        checkOutput("burst_cnt", 32'(burst_cnt), 32'(exp_cnt));
      end
    end
    afull_rec = alen_fifo_afull;
  end

  // Load a config, refresh the model and pulse update; then scramble the
  // config pins so only the snapshot can drive the transfer.
  task automatic applyStimulus(input int slen, input int snum, input int fnum, input int pnum);
    @(posedge clk);
    #2;
    seg_len  = 16'(slen);
    seg_num  = 12'(snum);
    frm_num  = 12'(fnum);
    part_num = 12'(pnum);
    exp_q.delete();
    exp_cnt  = 16'd0;
    if (slen != 0 && snum != 0 && fnum != 0 && pnum != 0) begin
      buildExpected(slen, snum, fnum, pnum);
    end
    update = 1'b1;
    @(posedge clk);
    #2;
    update   = 1'b0;
    seg_len  = 16'($urandom);
    seg_num  = 12'($urandom);
    frm_num  = 12'($urandom);
    part_num = 12'($urandom);
  endtask

  // Run until the model queue drains and the DUT is idle, resuming at each
  // part boundary. afull_mode: 0 none, 1 random, 2 one 5-cycle hold.
  task automatic runTransfer(input int afull_mode, input bit stop_at_pause);
    int  cyc;
    int  pwait;
    int  hold;
    bit  held;
    bit  done;
    cyc   = 0;
    pwait = 0;
    hold  = 0;
    held  = 1'b0;
    done  = 1'b0;
    while (!done) begin
      @(posedge clk);
      #2;
      resume = 1'b0;
      cyc++;
      if (cyc > 5000) begin
        checkOutput("transfer_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end else if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
      end else if (paused) begin
        pwait++;
        if (pwait == 3) begin
          checkOutput("plast_before_pause", 32'(last_pop[9]), 32'd1);
          checkOutput("no_push_in_pause", 32'(alen_fifo_push), 32'd0);
          if (stop_at_pause) begin
            done = 1'b1;
          end else begin
            resume = 1'b1;
            pwait  = 0;
          end
        end
      end
      case (afull_mode)
        1: alen_fifo_afull = ($urandom_range(0, 3) == 0);
        2: begin
          if (hold > 0) begin
            alen_fifo_afull = 1'b1;
            hold--;
          end else if (!held && exp_cnt >= 16'd1) begin
            alen_fifo_afull = 1'b1;
            hold = 4;
            held = 1'b1;
          end else begin
            alen_fifo_afull = 1'b0;
          end
        end
        default: alen_fifo_afull = 1'b0;
      endcase
    end
    alen_fifo_afull = 1'b0;
    resume          = 1'b0;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    exp_cnt         = 16'd0;
    last_pop        = 12'd0;
    afull_rec       = 1'b0;
    rst             = 1'b1;
    update          = 1'b0;
    resume          = 1'b0;
    alen_fifo_afull = 1'b0;
    seg_len         = 16'd0;
    seg_num         = 12'd0;
    frm_num         = 12'd0;
    part_num        = 12'd0;

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_push", 32'(alen_fifo_push), 32'd0);
    checkOutput("reset_din", 32'(alen_fifo_din), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_paused", 32'(paused), 32'd0);
    checkOutput("reset_cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("reset_burst_cnt", 32'(burst_cnt), 32'd0);

    $display("[TB] single segment split into 16/16/8");
    applyStimulus(40, 1, 1, 1);
    runTransfer(0, 1'b0);
    checkOutput("t1_last_desc", 32'(last_pop), 32'h0D07);
    checkOutput("t1_burst_cnt", 32'(burst_cnt), 32'd3);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    $display("[TB] two parts with pause and resume");
    applyStimulus(16, 2, 2, 2);
    runTransfer(0, 1'b0);
    checkOutput("t2_last_desc", 32'(last_pop), 32'h0D0F);
    checkOutput("t2_burst_cnt", 32'(burst_cnt), 32'd8);

    $display("[TB] afull hold mid-segment");
    applyStimulus(100, 1, 1, 1);
    runTransfer(2, 1'b0);
    checkOutput("t3_burst_cnt", 32'(burst_cnt), 32'd7);

    $display("[TB] illegal config");
    applyStimulus(0, 1, 1, 1);
    @(negedge clk);
    #1;
    checkOutput("cfg_err_pulse", 32'(cfg_err), 32'd1);
    checkOutput("cfg_err_busy", 32'(busy), 32'd0);
    checkOutput("cfg_err_burst_cnt", 32'(burst_cnt), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    checkOutput("cfg_err_no_push", 32'(alen_fifo_push), 32'd0);

    $display("[TB] update during pause restarts");
    applyStimulus(16, 2, 2, 2);
    runTransfer(0, 1'b1);
    checkOutput("t5_paused", 32'(paused), 32'd1);
    applyStimulus(8, 1, 1, 1);
    runTransfer(0, 1'b0);
    checkOutput("t5_first_desc", 32'(last_pop), 32'h0D07);
    checkOutput("t5_burst_cnt", 32'(burst_cnt), 32'd1);

    $display("[TB] reset during generation");
    applyStimulus(200, 1, 1, 1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    checkOutput("rst_push", 32'(alen_fifo_push), 32'd0);
    checkOutput("rst_din", 32'(alen_fifo_din), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_burst_cnt", 32'(burst_cnt), 32'd0);

    $display("[TB] resume while idle");
    @(posedge clk);
    #2;
    resume = 1'b1;
    @(posedge clk);
    #2;
    resume = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("idle_resume_busy", 32'(busy), 32'd0);
    checkOutput("idle_resume_cnt", 32'(burst_cnt), 32'd0);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(1, 50), $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
      runTransfer(1, 1'b0);
      checkOutput("rand_done_busy", 32'(busy), 32'd0);
      checkOutput("rand_final_c_last", 32'(last_pop[8]), 32'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
